// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, serial adder state encoding and digit validity check.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// bcd_serial_adder_if: request/result bundle between a client and the serial BCD adder.
interface bcd_serial_adder_if #(parameter int NDIG = 4);

    logic              start;
    logic [4*NDIG-1:0] a;
    logic [4*NDIG-1:0] b;
    logic              busy;
    logic              done;
    logic [4*NDIG-1:0] sum;
    logic              cout;
    logic              err;

    modport master (output start, a, b, input busy, done, sum, cout, err);
    modport slave  (input start, a, b, output busy, done, sum, cout, err);

endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal carry.
module bcd_digit_add
    import bcd_pkg::*;
(
    output logic       cout,
    output logic [3:0] s,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);

    logic [4:0] t;

    assign t    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign cout = t > {1'b0, BCD_MAX};
    assign s    = cout ? t[3:0] + BCD_ADJ : t[3:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: adds two packed-BCD operands one digit per clock, LSD first,
// collecting digit sums into a result register published on the final edge.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_adder_if.slave    bus
);

    localparam int W  = 4 * NDIG;
    localparam int IW = $clog2(NDIG + 1);

    state_t         state, state_nx;
    logic [IW-1:0]  idx;
    logic [W-1:0]   a_sr, b_sr, res_sr, res_nx, sum_q;
    logic [3:0]     s;
    logic           c, carry, done_q, cout_q, err_q, bad, accept, last;

    bcd_digit_add u_digit (
        .cout (c),
        .s    (s),
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .cin  (carry)
    );

    always_comb begin
        accept   = state == ST_IDLE && bus.start;
        last     = state == ST_RUN && idx == IW'(NDIG - 1);
        state_nx = state == ST_IDLE ? (bus.start ? ST_RUN : ST_IDLE)
                                    : (last ? ST_IDLE : ST_RUN);
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            bad = bad | !is_bcd(bus.a[4*i +: 4]) | !is_bcd(bus.b[4*i +: 4]);
    end

    // New digit enters at the top; after NDIG shifts digit 0 sits in [3:0].
    assign res_nx = W'({s, res_sr} >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_sr  <= bus.a;
                b_sr  <= bus.b;
                idx   <= '0;
                carry <= 1'b0;
                err_q <= bad;
            end else if (state == ST_RUN) begin
                a_sr   <= a_sr >> 4;
                b_sr   <= b_sr >> 4;
                res_sr <= res_nx;
                carry  <= c;
                idx    <= idx + IW'(1);
                if (last) begin
                    sum_q  <= res_nx;
                    cout_q <= c;
                end
            end
        end
    end

    assign bus.busy = state == ST_RUN;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule
